// File: rtl/button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_conditioner : synchronise, debounce and auto-repeat a 4-way pad + clear
// Rev 1.0
// ----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_up_n,
  input  logic raw_down_n,
  input  logic raw_left_n,
  input  logic raw_right_n,
  input  logic raw_clear_n,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic clear,
  output logic any_held
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] C_DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] C_PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Channel order: 0 right, 1 left, 2 down, 3 up, 4 clear (opposing pairs differ in bit 0)
  logic [4:0] w_raw_n;
  logic [4:0] w_lvl;
  logic [3:0] w_pulse;
  logic       clear_q;
  logic       any_held_q;

  assign w_raw_n = {raw_clear_n, raw_up_n, raw_down_n, raw_left_n, raw_right_n};

  generate
    for (genvar i = 0; i < 5; i++) begin : g_chan
      logic          sync1_q;
      logic          sync2_q;
      logic          lvl_q;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          lvl_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= w_raw_n[i];
          sync2_q <= sync1_q;
          if (~sync2_q == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == C_CNT_LAST) begin
            lvl_q <= ~lvl_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end

      assign w_lvl[i] = lvl_q;
    end
  endgenerate

  generate
    for (genvar i = 0; i < 4; i++) begin : g_dir
      state_t        state_q;
      logic [TW-1:0] timer_q;
      logic          pulse_q;
      logic          w_opposed;

      // Both sides of an axis pressed: FSMs keep timing, but steps are swallowed
      assign w_opposed = w_lvl[i] & w_lvl[i ^ 1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= S_IDLE;
          timer_q <= '0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= 1'b0;
          if (w_lvl[4] || !w_lvl[i]) begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end else begin
            case (state_q)
              S_IDLE: begin
                state_q <= S_DELAY;
                timer_q <= C_DELAY_LOAD;
                pulse_q <= ~w_opposed;
              end
              S_DELAY: begin
                if (timer_q == '0) begin
                  state_q <= S_REPEAT;
                  timer_q <= C_PERIOD_LOAD;
                  pulse_q <= ~w_opposed;
                end else begin
                  timer_q <= timer_q - TW'(1);
                end
              end
              S_REPEAT: begin
                if (timer_q == '0) begin
                  timer_q <= C_PERIOD_LOAD;
                  pulse_q <= ~w_opposed;
                end else begin
                  timer_q <= timer_q - TW'(1);
                end
              end
              default: begin
                state_q <= S_IDLE;
                timer_q <= '0;
              end
            endcase
          end
        end
      end

      assign w_pulse[i] = pulse_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_q    <= 1'b0;
      any_held_q <= 1'b0;
    end else begin
      clear_q    <= w_lvl[4];
      any_held_q <= |w_lvl[3:0];
    end
  end

  assign move_right = w_pulse[0];
  assign move_left  = w_pulse[1];
  assign move_down  = w_pulse[2];
  assign move_up    = w_pulse[3];
  assign clear      = clear_q;
  assign any_held   = any_held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_button_conditioner : vector table + scoreboard bench for button_conditioner
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_up_n, raw_down_n, raw_left_n, raw_right_n, raw_clear_n;
  logic move_up, move_down, move_left, move_right, clear, any_held;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_up_n   (raw_up_n),
    .raw_down_n (raw_down_n),
    .raw_left_n (raw_left_n),
    .raw_right_n(raw_right_n),
    .raw_clear_n(raw_clear_n),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .clear      (clear),
    .any_held   (any_held)
  );

  // dirs: [3] up, [2] down, [1] left, [0] right; masks hold one bit per cycle
  typedef struct {
    string       name;
    logic [3:0]  dirs;
    int          p;
    int          r;
    int          cp;
    int          cr;
    int          n;
    logic [63:0] eu, ed, el, er, ec, eh;
  } vec_t;

  vec_t       vecs[6];
  logic [5:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [63:0] pm(input int a = -1, input int b = -1, input int c = -1,
                                     input int d = -1, input int e = -1, input int f = -1,
                                     input int g = -1, input int h = -1);
    logic [63:0] m;
    int          t[8];
    m = '0;
    t = '{a, b, c, d, e, f, g, h};
    for (int k = 0; k < 8; k++) if (t[k] >= 0) m[t[k]] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k < hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input string nm, input logic [3:0] d, input int p, input int r,
                              input int cp, input int cr, input int n,
                              input logic [63:0] eu, input logic [63:0] ed,
                              input logic [63:0] el, input logic [63:0] er,
                              input logic [63:0] ec, input logic [63:0] eh);
    vec_t v;
    v.name = nm; v.dirs = d; v.p = p; v.r = r; v.cp = cp; v.cr = cr; v.n = n;
    v.eu = eu; v.ed = ed; v.el = el; v.er = er; v.ec = ec; v.eh = eh;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {move_up, move_down, move_left, move_right, clear, any_held};
  endfunction

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {u,d,l,r,clr,held}=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dirs, input logic clr);
    raw_up_n    = ~dirs[3];
    raw_down_n  = ~dirs[2];
    raw_left_n  = ~dirs[1];
    raw_right_n = ~dirs[0];
    raw_clear_n = ~clr;
  endtask

  // Leaves the bench 1 time unit after edge 0, i.e. at the start of cycle 0
  task automatic do_reset();
    drive(4'b0000, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("reset state", outs(), 6'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic [5:0] exp);
    logic [5:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    chk(nm, outs(), e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] d;
    logic       c_on;
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c < v.n; c++) begin
      d    = (c >= v.p && c < v.r) ? v.dirs : 4'b0000;
      c_on = (v.cp >= 0 && c >= v.cp && c < v.cr);
      drive(d, c_on);
      exp = {v.eu[c[5:0]], v.ed[c[5:0]], v.el[c[5:0]], v.er[c[5:0]], v.ec[c[5:0]], v.eh[c[5:0]]};
      step($sformatf("%s c%0d", v.name, c), exp);
    end
    drive(4'b0000, 1'b0);
  endtask

  initial begin
    logic [63:0] mu, mh;
    logic [5:0]  exp;

    reset_n = 1'b0;
    drive(4'b0000, 1'b0);

    // Level accepted at press+6, first step at press+7; release also takes 6 cycles to register
    vecs[0] = mk("up tap", 4'b1000, 0, 8, -1, -1, 30,
                 pm(7), 64'd0, 64'd0, 64'd0, 64'd0, rng(7, 15));
    vecs[1] = mk("right glitch", 4'b0001, 0, 3, -1, -1, 20,
                 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    vecs[2] = mk("left repeat", 4'b0010, 0, 30, -1, -1, 60,
                 64'd0, 64'd0, pm(7, 17, 20, 23, 26, 29, 32, 35), 64'd0, 64'd0, rng(7, 37));
    vecs[3] = mk("up+down", 4'b1100, 0, 20, -1, -1, 40,
                 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, rng(7, 27));
    vecs[4] = mk("down+clear", 4'b0100, 0, 60, 12, 30, 60,
                 64'd0, pm(7, 17, 37, 47, 50, 53, 56, 59), 64'd0, 64'd0, rng(19, 37), rng(7, 60));
    vecs[5] = mk("up+right", 4'b1001, 0, 12, -1, -1, 30,
                 pm(7, 17), 64'd0, 64'd0, pm(7, 17), 64'd0, rng(7, 19));

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Mid-DELAY reset: asynchronous clear, then the still-held button is a fresh press
    do_reset();
    mu = pm(7, 24);
    mh = rng(7, 15) | rng(24, 32);
    for (int c = 0; c < 45; c++) begin
      drive((c < 25) ? 4'b1000 : 4'b0000, 1'b0);
      if (c == 15) begin
        #2 reset_n = 1'b0;
        #1 chk("async reset", outs(), 6'b0);
      end
      if (c == 17) reset_n = 1'b1;
      exp = {mu[c[5:0]], 3'b000, 1'b0, mh[c[5:0]]};
      step($sformatf("reset seq c%0d", c), exp);
    end

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
